// File: rtl/ifd_pkg.sv
// Shared types for the fetch/decode stage.
// Optional feature macro: IFD_ILLEGAL_HALT_EN (halt fetching on an illegal opcode).
package ifd_pkg;

  typedef enum logic [1:0] {
    T_ILLEGAL = 2'd0,
    T_I       = 2'd1,
    T_R       = 2'd2,
    T_S       = 2'd3
  } instr_type_e;

  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_STORE = 7'h03;

  typedef struct packed {
    instr_type_e itype;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] pc;
  } dec_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } ifd_state_e;

endpackage

// File: rtl/ifd_fifo.sv
// Synchronous FIFO of decoded packets; head reads as zero while empty.
module ifd_fifo
  import ifd_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  dec_pkt_t                 push_data,
  input  logic                     pop,
  output dec_pkt_t                 head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  dec_pkt_t       mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  // Storage, pointers and occupancy; the push side relies on upstream credit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage with credit-limited requests and a packet FIFO.
// Optional feature macro: IFD_ILLEGAL_HALT_EN (halt fetching on an illegal opcode).
module instr_fetch_decode
  import ifd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic        next_op,
  input  logic [31:0] instr,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [1:0]  dec_type,
  output logic [6:0]  dec_opcode,
  output logic [4:0]  dec_rd,
  output logic [4:0]  dec_rs1,
  output logic [4:0]  dec_rs2,
  output logic [2:0]  dec_funct3,
  output logic [6:0]  dec_funct7,
  output logic [31:0] dec_imm,
  output logic [31:0] dec_pc,
  output logic        illegal_halt
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH);

  ifd_state_e    state;
  logic          inflight;
  logic [31:0]   pc;
  dec_pkt_t      pkt;
  dec_pkt_t      head;
  logic          push;
  logic          pop;
  logic [CW:0]   count;
  logic [CW+1:0] committed;

  assign push = inflight;
  assign pop  = dec_valid && dec_ready;

  // Slots already owned (buffered + in flight - leaving now) bound new requests.
  assign committed = (CW+2)'(count) + (CW+2)'(inflight) - (CW+2)'(pop);
  assign next_op   = (state == ST_RUN) && (committed < (CW+2)'(FIFO_DEPTH));

  // Decode the word returned for the previous cycle's request.
  always_comb begin
    pkt        = '0;
    pkt.opcode = instr[6:0];
    pkt.rs1    = instr[19:15];
    pkt.funct3 = instr[14:12];
    pkt.pc     = pc;
    case (instr[6:0])
      OP_IMM: begin
        pkt.itype = T_I;
        pkt.rd    = instr[11:7];
        pkt.imm   = {{20{instr[31]}}, instr[31:20]};
      end
      OP_REG: begin
        pkt.itype  = T_R;
        pkt.rd     = instr[11:7];
        pkt.rs2    = instr[24:20];
        pkt.funct7 = instr[31:25];
      end
      OP_STORE: begin
        pkt.itype = T_S;
        pkt.rs2   = instr[24:20];
        pkt.imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      default: begin
        pkt.itype = T_ILLEGAL;
        pkt.rs2   = instr[24:20];
      end
    endcase
  end

  // Control FSM, in-flight tracking and PC stamping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      inflight <= 1'b0;
      pc       <= PC_RESET;
    end else begin
      inflight <= next_op;
      if (push) begin
        pc <= pc + 32'd4;
      end
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
`ifdef IFD_ILLEGAL_HALT_EN
          if (push && (pkt.itype == T_ILLEGAL)) state <= ST_HALT;
          else if (!enable)                     state <= ST_IDLE;
`else
          if (!enable) state <= ST_IDLE;
`endif
        end
`ifdef IFD_ILLEGAL_HALT_EN
        ST_HALT: state <= ST_HALT;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IFD_ILLEGAL_HALT_EN
  assign illegal_halt = (state == ST_HALT);
`else
  assign illegal_halt = 1'b0;
`endif

  ifd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (pkt),
    .pop       (pop),
    .head      (head),
    .valid     (dec_valid),
    .count     (count)
  );

  assign dec_type   = head.itype;
  assign dec_opcode = head.opcode;
  assign dec_rd     = head.rd;
  assign dec_rs1    = head.rs1;
  assign dec_rs2    = head.rs2;
  assign dec_funct3 = head.funct3;
  assign dec_funct7 = head.funct7;
  assign dec_imm    = head.imm;
  assign dec_pc     = head.pc;

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetch-and-decode stage directly downstream of the instruction memory. Pulses `next_op` to pull one 32-bit instruction per request from the memory, captures the word one cycle later, and decodes it into type, register fields, sign-extended immediate and PC. Decoded packets are buffered in a small FIFO and handed to the execute stage over a valid/ready handshake. Request issue is credit-limited so no fetched word is ever dropped.

## Interface
- `FIFO_DEPTH`, 2, decoded-packet buffer entries; power of two, ≥2.
- `PC_RESET`, 32'h0, PC of the first fetched instruction.

Ports:
- `clock`  in  1  single clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  fetch enable; low stops new requests.
- `next_op`  out  1  request to instruction memory; word appears on `instr` the following cycle.
- `instr`  in  32  instruction word from memory.
- `dec_valid`  out  1  head packet valid.
- `dec_ready`  in  1  consumer accepts the head packet.
- `dec_type`  out  2  `ILLEGAL`=0, `I`=1, `R`=2, `S`=3.
- `dec_opcode`  out  7  `instr[6:0]`.
- `dec_rd`  out  5  `instr[11:7]`; 0 for S and ILLEGAL.
- `dec_rs1`  out  5  `instr[19:15]`.
- `dec_rs2`  out  5  `instr[24:20]`; 0 for I.
- `dec_funct3`  out  3  `instr[14:12]`.
- `dec_funct7`  out  7  `instr[31:25]` for R, else 0.
- `dec_imm`  out  32  sign-extended immediate.
- `dec_pc`  out  32  byte PC of the packet.
- `illegal_halt`  out  1  halted on illegal opcode.

## Operation
- Opcode map: 7'h13 → I; 7'h33 → R; 7'h03 → S (team store encoding); anything else → ILLEGAL.
- Immediate: I = sext(`instr[31:20]`); S = sext({`instr[31:25]`,`instr[11:7]`}); R and ILLEGAL = 0.
- `inflight` flag: set in a cycle where `next_op`=1, cleared the next cycle. Whenever `inflight` is 1, `instr` is decoded and pushed; push is unconditional (space is guaranteed by credit).
- Credit rule: `next_op` = `state`==RUN && (`count` + `inflight` − pop) < `FIFO_DEPTH`, pop = `dec_valid`&&`dec_ready`.
- PC counter starts at `PC_RESET`, stamped into each pushed packet, then +4; wraps modulo 2^32.
- FSM: IDLE → RUN when `enable`=1; RUN → IDLE when `enable`=0 (in-flight word still captured); RUN → HALT on pushing an ILLEGAL packet (macro only); HALT exits only via reset.
- `dec_*` are the FIFO head, stable while `dec_valid`=1 && `dec_ready`=0.

## Timing
- Reset: `next_op`=0, `dec_valid`=0, all `dec_*`=0, `illegal_halt`=0, `count`=0, `inflight`=0, PC=`PC_RESET`, state IDLE. Asserting reset mid-stream discards FIFO and in-flight word.
- Latency: `next_op` at cycle N → packet pushed at edge N+1 → `dec_valid` at N+2.
- Throughput: one packet/cycle sustained with `dec_ready` held high, `FIFO_DEPTH`=2.
- FIFO full and pop in same cycle: new request allowed. Push and pop same cycle: `count` unchanged.
- Empty FIFO: `dec_valid`=0; no bypass of capture register.

## Configuration
- `IFD_ILLEGAL_HALT_EN` defined: ILLEGAL packet is pushed, FSM enters HALT, `next_op` forced 0, `illegal_halt`=1 from next cycle; already-buffered packets still drain.
- Undefined: ILLEGAL packets flow with `dec_type`=0, fetching continues, `illegal_halt` tied 0, no HALT state.

## Structure
- Package `ifd_pkg`: `instr_type_e` enum, opcode localparams (`OP_IMM`, `OP_REG`, `OP_STORE`), `dec_pkt_t` struct (type, opcode, rd, rs1, rs2, funct3, funct7, imm, pc), `ifd_state_e`.
- Sub-module `ifd_fifo`: parameterised synchronous FIFO of `dec_pkt_t` with `count` output; decode is combinational logic in the top before push.

## Test plan
- `instr`=32'h00A00093 → I, rd=1, rs1=0, funct3=0, imm=10, pc=0.
- `instr`=32'h00108133 → R, rd=2, rs1=1, rs2=1, funct7=0, imm=0.
- `instr`=32'h00208203 → S, opcode 7'h03, rs1=1, rs2=2, rd=0, imm=4.
- `dec_ready`=0 for 10 cycles with `enable`=1 → exactly 2 `next_op` pulses, head fields stable, then release yields pc 0,4,8… in order, no loss or duplication.
- `instr`=32'hFFFFFFFF → ILLEGAL; with `IFD_ILLEGAL_HALT_EN` `next_op` stays 0 and `illegal_halt`=1; without, fetching continues.
- `reset_n` low mid-stream with FIFO full → `dec_valid`=0 asynchronously, first post-reset packet pc=`PC_RESET`.
